idct2_4_1: RTL
==============

# idct2_4_1

Pipelined 4-point inverse DCT-II (VVC integer kernel) for one row or column. It is the inverse counterpart of the forward `dct2_4_1` partial-butterfly stage. It accepts four coefficients per beat over a valid/ready handshake, performs the even/odd butterfly with multiplier-less constants 64/83/36, rounds, shifts and clips, and emits four residual samples two cycles later. Two instances, one for columns with SHIFT=7 and one for rows with SHIFT=20−bitdepth, form the 2-D inverse 4×4 path.

## Interface
- `IN_W`, 16: signed coefficient width.
- `OUT_W`, 16: signed output sample width; the clip range is [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- `SHIFT`, 7: right shift after rounding, range 1..24.

Ports:
- `clk` in 1: clock. One clock domain; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: coefficient beat valid.
- `in_ready` out 1: block can accept a beat.
- `C[0:3]` in 4×IN_W signed: coefficients, low frequency first.
- `out_valid` out 1: sample beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `Y[0:3]` out 4×OUT_W signed: reconstructed samples.
- `sat` out 1: at least one of `Y[0:3]` was clipped in this beat.

## Operation
- Even part: E0 = 64·C0 + 64·C2 and E1 = 64·C0 − 64·C2, both by shift.
- Odd part: O0 = 83·C1 + 36·C3 and O1 = 36·C1 − 83·C3, both by shift-add. No multipliers are used.
- Recombination: y0 = E0+O0, y1 = E1+O1, y2 = E1−O1, y3 = E0−O0.
- Output: Yk = clip((yk + 2^(SHIFT−1)) >>> SHIFT). The shift is arithmetic, so it floors toward −∞.
- Widths:
  - E and O fit in IN_W+7 bits.
  - yk fits in IN_W+8 bits.
  - The rounding add is done at IN_W+9 bits and must never wrap.
- `sat` is the OR of the four per-sample clip conditions.
- Stage 1 (S1) registers E0, E1, O0, O1 and the valid bit `v1`.
- Stage 2 (S2) registers Y, `sat` and `out_valid`.
- Stage enables:
  - S2 loads when `!out_valid || out_ready`.
  - S1 loads when `!v1` or S2 loads.
  - `in_ready` = `!v1 || S2_load`. It is combinational from `out_ready`, with no combinational path from `in_valid`.
- A beat transfers on `in_valid && in_ready`, and the output side on `out_valid && out_ready`.
- A bubble in S1 propagates: S2 loads with `out_valid=0`.
- Data registers hold their value when their stage is not loading. While `out_valid=1` and `out_ready=0`, `Y` and `sat` remain stable.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream) clears `v1`, `out_valid` and `sat`, and sets Y[0:3]=0 and E/O=0.
- `in_ready`=1 during reset and in the first cycle after it.
- Latency: a beat accepted at edge n appears with `out_valid=1` after edge n+2 when there is no backpressure.
- Throughput: one beat per cycle while `out_ready`=1.
- Storage: with `out_ready` held 0, the block absorbs exactly 2 beats, then `in_ready`=0.
- Release: when `out_ready` returns to 1, `in_ready` goes to 1 in the same cycle. No beat is lost or duplicated.
- Simultaneous accept and drain in the full state is legal and keeps full occupancy.
- Reset mid-stream discards both in-flight beats. There is no partial output.

## Structure
- Package `idct_pkg`:
  - constants K64=64, K83=83, K36=36;
  - the width function for IN_W+9;
  - the clip helper function.
- Sub-module `isau_2o`: a shift-add unit that produces 36·x and 83·x from one signed input. It is instantiated twice, for C1 and C3.
- All other logic stays in the top module.

## Test plan
- DC case: C=[64,0,0,0] with SHIFT=7 gives Y=[32,32,32,32] and `sat`=0, two cycles after acceptance.
- Odd basis and rounding: C=[0,64,0,0] gives Y=[42,18,−18,−41]. This checks the floor behaviour on negative values.
- Saturation: C=[32767,32767,32767,32767] gives Y=[32767,−12032,12032,2304] and `sat`=1.
- Backpressure: stream beats 1..5 while `out_ready`=0 for 4 cycles.
  - `in_ready` drops after 2 beats are accepted.
  - Y stays stable while `out_valid` is held.
  - After release, all 5 beats arrive in order with no duplicates.
- Reset mid-stream: assert `rst_n`=0 with 2 beats in flight. `out_valid`=0 and Y=0 immediately; after release, a fresh beat appears at latency 2.
- Random regression: 10k random coefficient vectors with random valid/ready, compared against the golden model clip((y+2^(SHIFT−1))>>>SHIFT) for SHIFT=7 and SHIFT=10.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants and helpers for the inverse DCT-II datapath.
package idct_pkg;

   localparam int K64 = 64;
   localparam int K83 = 83;
   localparam int K36 = 36;

   // Width of the rounding adder: one bit above the recombined sum, so the rounding add cannot wrap.
   function automatic int unsigned rnd_w(input int unsigned in_w);
      return in_w + 9;
   endfunction

   function automatic logic signed [63:0] clip_s(input logic signed [63:0] v,
                                                 input int unsigned    w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/isau_2o.sv
// Shift-add unit: 36*x and 83*x from one signed input, no multipliers.
module isau_2o
   import idct_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic signed [W-1:0] x,
   output logic signed [W+6:0] x36,
   output logic signed [W+6:0] x83
);

   logic signed [W+6:0] xe;

   assign xe  = (W + 7)'(x);
   // 36 = 32 + 4, 83 = 64 + 16 + 2 + 1
   assign x36 = (xe <<< 5) + (xe <<< 2);
   assign x83 = (xe <<< 6) + (xe <<< 4) + (xe <<< 1) + xe;

endmodule

// File: rtl/idct2_4_1.sv
// Two-stage pipelined 4-point inverse DCT-II (even/odd butterfly, round, shift, clip).
module idct2_4_1
   import idct_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SHIFT = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  C [0:3],
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] Y [0:3],
   output logic                    sat
);

   localparam int unsigned EW  = IN_W + 7;
   localparam int unsigned YW  = IN_W + 8;
   localparam int unsigned RW  = rnd_w(IN_W);
   localparam int unsigned KSH = $clog2(K64);
   localparam logic signed [RW-1:0] RND = RW'(1) <<< (SHIFT - 1);

   logic s1_load, s2_load;
   logic v1;

   logic signed [EW-1:0] c0e, c2e;
   logic signed [EW-1:0] m36_1, m83_1, m36_3, m83_3;
   logic signed [EW-1:0] e0_d, e1_d, o0_d, o1_d;
   logic signed [EW-1:0] e0_q, e1_q, o0_q, o1_q;

   logic signed [YW-1:0]    ysum [0:3];
   logic signed [OUT_W-1:0] y_d  [0:3];
   logic [3:0]              clip;

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !v1 || s2_load;
   assign in_ready = s1_load;

   isau_2o #(.W(IN_W)) u_odd1 (
      .x   (C[1]),
      .x36 (m36_1),
      .x83 (m83_1)
   );

   isau_2o #(.W(IN_W)) u_odd3 (
      .x   (C[3]),
      .x36 (m36_3),
      .x83 (m83_3)
   );

   assign c0e  = EW'(C[0]);
   assign c2e  = EW'(C[2]);
   assign e0_d = (c0e + c2e) <<< KSH;
   assign e1_d = (c0e - c2e) <<< KSH;
   assign o0_d = m83_1 + m36_3;
   assign o1_d = m36_1 - m83_3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         e0_q <= '0;
         e1_q <= '0;
         o0_q <= '0;
         o1_q <= '0;
      end else if (s1_load) begin
         v1 <= in_valid;
         if (in_valid) begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            o0_q <= o0_d;
            o1_q <= o1_d;
         end
      end
   end

   assign ysum[0] = YW'(e0_q) + YW'(o0_q);
   assign ysum[1] = YW'(e1_q) + YW'(o1_q);
   assign ysum[2] = YW'(e1_q) - YW'(o1_q);
   assign ysum[3] = YW'(e0_q) - YW'(o0_q);

   for (genvar k = 0; k < 4; k++) begin : g_out
      logic signed [RW-1:0] rsum;
      logic signed [RW-1:0] rsh;
      logic signed [63:0]   rcl;
      assign rsum    = RW'(ysum[k]) + RND;
      assign rsh     = rsum >>> SHIFT;
      assign rcl     = clip_s(64'(rsh), OUT_W);
      assign y_d[k]  = OUT_W'(rcl);
      assign clip[k] = (rcl != 64'(rsh));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sat       <= 1'b0;
         for (int k = 0; k < 4; k++) Y[k] <= '0;
      end else if (s2_load) begin
         out_valid <= v1;
         // A bubble leaves the previous sample values in place.
         if (v1) begin
            sat <= |clip;
            for (int k = 0; k < 4; k++) Y[k] <= y_d[k];
         end
      end
   end

endmodule
